// File: rtl/countdown_pkg.sv
// Shared types and constants for the three-digit BCD countdown timer.
// Holds the FSM encoding, the BCD digit ceiling and the default prescaler period.
package countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX          = 4'd9;
    localparam int         TICK_MAX_DEFAULT = 50_000_000;

    typedef struct packed {
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
    } bcd3_t;

    // Digits entered as A..F are treated as the largest legal BCD digit.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] digit);
        return (digit > BCD_MAX) ? BCD_MAX : digit;
    endfunction

    function automatic bcd3_t bcd3_clamp(input bcd3_t value);
        bcd3_t result;
        result.d2 = bcd_clamp(value.d2);
        result.d1 = bcd_clamp(value.d1);
        result.d0 = bcd_clamp(value.d0);
        return result;
    endfunction

endpackage

// File: rtl/countdown_tick_gen.sv
// Prescaler for the countdown timer: counts enabled cycles and strobes tick on
// the cycle in which the count wraps from TICK_MAX-1 back to 0.
module countdown_tick_gen #(
    parameter int TICK_MAX = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    input  logic sync_clear,
    output logic tick
);

    localparam int             CW   = (TICK_MAX > 2) ? $clog2(TICK_MAX) : 1;
    localparam logic [CW-1:0]  LAST = CW'(TICK_MAX - 1);

    logic [CW-1:0] cnt;
    logic          at_last;

    assign at_last = (cnt == LAST);

    // The strobe is combinational so the parent can step the count on the
    // very edge where the prescaler wraps.
    assign tick = en && !sync_clear && at_last;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt <= '0;
        end else if (sync_clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= at_last ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Three-digit BCD countdown timer with load, run/pause, and a latched alarm.
// Every output is a flop; the FSM computes next values and registers them.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int TICK_MAX = TICK_MAX_DEFAULT
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       load,
    input  logic       go,
    input  logic [3:0] set_d0,
    input  logic [3:0] set_d1,
    input  logic [3:0] set_d2,
    output logic [3:0] d0,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic       running,
    output logic       alarm,
    output logic       expire
);

    state_t state;
    state_t next_state;

    bcd3_t  count;
    bcd3_t  count_set;
    bcd3_t  count_dec;
    logic   count_zero;
    logic   dec_zero;

    logic   tick;
    logic   tick_en;

    logic   running_nxt;
    logic   alarm_nxt;
    logic   expire_nxt;

    // A pause takes effect on the cycle go drops, so the prescaler never
    // advances in the RUN->PAUSE transition cycle.
    assign tick_en = (state == ST_RUN) && go;

    countdown_tick_gen #(
        .TICK_MAX (TICK_MAX)
    ) u_tick_gen (
        .clk        (clk),
        .clr        (clr),
        .en         (tick_en),
        .sync_clear (load),
        .tick       (tick)
    );

    assign count_set  = bcd3_clamp('{d2: set_d2, d1: set_d1, d0: set_d0});
    assign count_zero = (count == '0);
    assign dec_zero   = (count_dec == '0);

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        count_dec = count;
        if (count_zero) begin
            count_dec = '0;
        end else if (count.d0 != 4'd0) begin
            count_dec.d0 = count.d0 - 4'd1;
        end else begin
            count_dec.d0 = BCD_MAX;
            if (count.d1 != 4'd0) begin
                count_dec.d1 = count.d1 - 4'd1;
            end else begin
                count_dec.d1 = BCD_MAX;
                count_dec.d2 = count.d2 - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count <= '0;
        end else if (load) begin
            count <= count_set;
        end else if (tick && !count_zero) begin
            count <= count_dec;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= ST_IDLE;
            running <= 1'b0;
            alarm   <= 1'b0;
            expire  <= 1'b0;
        end else begin
            state   <= next_state;
            running <= running_nxt;
            alarm   <= alarm_nxt;
            expire  <= expire_nxt;
        end
    end

    always_comb begin
        next_state = state;
        if (load) begin
            next_state = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (go && !count_zero) begin
                        next_state = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!go) begin
                        next_state = ST_PAUSE;
                    end else if (tick && dec_zero) begin
                        next_state = ST_DONE;
                    end
                end
                ST_PAUSE: begin
                    if (go) begin
                        next_state = ST_RUN;
                    end
                end
                ST_DONE: begin
                    next_state = ST_DONE;
                end
                default: begin
                    next_state = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from next_state and then registered, which keeps them
    // cycle-aligned with state while avoiding any input-to-output comb path.
    always_comb begin
        running_nxt = (next_state == ST_RUN);
        alarm_nxt   = (next_state == ST_DONE);
        expire_nxt  = (next_state == ST_DONE) && (state != ST_DONE);
    end

    assign d0 = count.d0;
    assign d1 = count.d1;
    assign d2 = count.d2;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: a vector table on a TICK_MAX=2 instance
// plus hand sequences for asynchronous clear on a TICK_MAX=3 instance.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       clr;
    logic       load;
    logic       go;
    logic [3:0] set_d0, set_d1, set_d2;

    logic [3:0] a_d0, a_d1, a_d2;
    logic       a_running, a_alarm, a_expire;
    logic [3:0] b_d0, b_d1, b_d2;
    logic       b_running, b_alarm, b_expire;

    logic [14:0] out_a;
    logic [14:0] out_b;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic        load;
        logic        go;
        logic [11:0] set;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    countdown_timer #(.TICK_MAX(2)) dut_a (
        .clk     (clk),
        .clr     (clr),
        .load    (load),
        .go      (go),
        .set_d0  (set_d0),
        .set_d1  (set_d1),
        .set_d2  (set_d2),
        .d0      (a_d0),
        .d1      (a_d1),
        .d2      (a_d2),
        .running (a_running),
        .alarm   (a_alarm),
        .expire  (a_expire)
    );

    countdown_timer #(.TICK_MAX(3)) dut_b (
        .clk     (clk),
        .clr     (clr),
        .load    (load),
        .go      (go),
        .set_d0  (set_d0),
        .set_d1  (set_d1),
        .set_d2  (set_d2),
        .d0      (b_d0),
        .d1      (b_d1),
        .d2      (b_d2),
        .running (b_running),
        .alarm   (b_alarm),
        .expire  (b_expire)
    );

    assign out_a = {a_d2, a_d1, a_d0, a_running, a_alarm, a_expire};
    assign out_b = {b_d2, b_d1, b_d0, b_running, b_alarm, b_expire};

    function automatic logic [14:0] expv(input logic [11:0] dig, input logic run,
                                         input logic alm, input logic exp);
        return {dig, run, alm, exp};
    endfunction

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got digits=%h run=%b alarm=%b expire=%b, want digits=%h run=%b alarm=%b expire=%b",
                     name, act[14:3], act[2], act[1], act[0], exp[14:3], exp[2], exp[1], exp[0]);
        end else begin
            passed++;
        end
    endtask

    task automatic add(input logic ld, input logic g, input logic [11:0] s,
                       input logic [11:0] dig, input logic run, input logic alm, input logic exp);
        vec_t v;
        v.load = ld;
        v.go   = g;
        v.set  = s;
        v.exp  = expv(dig, run, alm, exp);
        vecs.push_back(v);
    endtask

    task automatic drive(input logic ld, input logic g, input logic [11:0] s);
        load = ld;
        go   = g;
        {set_d2, set_d1, set_d0} = s;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Load 100, run: 099 after two RUN cycles, 098 two later.
        add(1, 0, 12'h100, 12'h100, 0, 0, 0);
        add(0, 1, 12'h000, 12'h100, 1, 0, 0);
        add(0, 1, 12'h000, 12'h100, 1, 0, 0);
        add(0, 1, 12'h000, 12'h099, 1, 0, 0);
        add(0, 1, 12'h000, 12'h099, 1, 0, 0);
        add(0, 1, 12'h000, 12'h098, 1, 0, 0);
        add(0, 1, 12'h000, 12'h098, 1, 0, 0);
        // Pause for 10 cycles with the prescaler at 1; then one RUN cycle to step.
        for (int i = 0; i < 10; i++) add(0, 0, 12'h000, 12'h098, 0, 0, 0);
        add(0, 1, 12'h000, 12'h098, 1, 0, 0);
        add(0, 1, 12'h000, 12'h097, 1, 0, 0);
        // Clamped load has priority over go, then a load during RUN.
        add(1, 1, 12'hFA3, 12'h993, 0, 0, 0);
        add(0, 1, 12'h000, 12'h993, 1, 0, 0);
        add(0, 1, 12'h000, 12'h993, 1, 0, 0);
        add(0, 1, 12'h000, 12'h992, 1, 0, 0);
        add(1, 1, 12'h005, 12'h005, 0, 0, 0);
        add(0, 0, 12'h000, 12'h005, 0, 0, 0);
        // Count 002 to expiry; go is ignored in DONE.
        add(1, 0, 12'h002, 12'h002, 0, 0, 0);
        add(0, 1, 12'h000, 12'h002, 1, 0, 0);
        add(0, 1, 12'h000, 12'h002, 1, 0, 0);
        add(0, 1, 12'h000, 12'h001, 1, 0, 0);
        add(0, 1, 12'h000, 12'h001, 1, 0, 0);
        add(0, 1, 12'h000, 12'h000, 0, 1, 1);
        add(0, 1, 12'h000, 12'h000, 0, 1, 0);
        add(0, 0, 12'h000, 12'h000, 0, 1, 0);
        add(0, 1, 12'h000, 12'h000, 0, 1, 0);
        add(0, 0, 12'h000, 12'h000, 0, 1, 0);
        // Load clears the alarm; go with count 000 stays idle, no expire.
        add(1, 0, 12'h000, 12'h000, 0, 0, 0);
        add(0, 1, 12'h000, 12'h000, 0, 0, 0);
        add(0, 1, 12'h000, 12'h000, 0, 0, 0);

        // Asynchronous clear with arbitrary inputs, before any clock edge.
        clr = 1'b1;
        drive(1, 1, 12'hFFF);
        #1 clr = 1'b0;
        #1;
        check("reset_async_a", out_a, expv(12'h000, 0, 0, 0));
        check("reset_async_b", out_b, expv(12'h000, 0, 0, 0));

        @(negedge clk);
        clr = 1'b1;
        drive(0, 1, 12'h000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("post_reset_idle%0d", i), out_a, expv(12'h000, 0, 0, 0));
        end

        foreach (vecs[i]) begin
            drive(vecs[i].load, vecs[i].go, vecs[i].set);
            @(negedge clk);
            check($sformatf("vec%0d", i), out_a, vecs[i].exp);
        end

        // TICK_MAX=3: step after three RUN cycles, then clear during DONE.
        drive(1, 0, 12'h001);
        @(negedge clk);
        check("b_load_001", out_b, expv(12'h001, 0, 0, 0));
        drive(0, 1, 12'h000);
        @(negedge clk);
        check("b_run_p0", out_b, expv(12'h001, 1, 0, 0));
        @(negedge clk);
        check("b_run_p1", out_b, expv(12'h001, 1, 0, 0));
        @(negedge clk);
        check("b_run_p2", out_b, expv(12'h001, 1, 0, 0));
        @(negedge clk);
        check("b_expire", out_b, expv(12'h000, 0, 1, 1));
        @(negedge clk);
        check("b_alarm_hold", out_b, expv(12'h000, 0, 1, 0));
        @(posedge clk);
        #2 clr = 1'b0;
        #1;
        check("b_clr_in_done", out_b, expv(12'h000, 0, 0, 0));
        #1 clr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("b_after_done_clr0", out_b, expv(12'h000, 0, 0, 0));
        @(negedge clk);
        check("b_after_done_clr1", out_b, expv(12'h000, 0, 0, 0));

        // TICK_MAX=3: clear in the middle of RUN discards the count.
        drive(1, 0, 12'h003);
        @(negedge clk);
        check("b_load_003", out_b, expv(12'h003, 0, 0, 0));
        drive(0, 1, 12'h000);
        @(negedge clk);
        check("b_run3_p0", out_b, expv(12'h003, 1, 0, 0));
        @(negedge clk);
        check("b_run3_p1", out_b, expv(12'h003, 1, 0, 0));
        @(posedge clk);
        #2 clr = 1'b0;
        #1;
        check("b_clr_in_run", out_b, expv(12'h000, 0, 0, 0));
        check("a_clr_in_run", out_a, expv(12'h000, 0, 0, 0));
        #1 clr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("b_after_run_clr0", out_b, expv(12'h000, 0, 0, 0));
        @(negedge clk);
        check("b_after_run_clr1", out_b, expv(12'h000, 0, 0, 0));
        check("a_after_run_clr", out_a, expv(12'h000, 0, 0, 0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter TICK_MAX, default 50000000, clock cycles per count step (the 1 s period at 50 MHz); legal range is 2 or more.
REQ-002 clk  input  1  single system clock; all state changes on the rising edge.
REQ-003 clr  input  1  reset; asynchronous, active-low.
REQ-004 load  input  1  level; latches set_d2..set_d0 as the new start value.
REQ-005 go  input  1  level; 1 = count down, 0 = pause.
REQ-006 set_d0, set_d1, set_d2  input  4 each  BCD start value; d2 = hundreds, d0 = units.
REQ-007 d0, d1, d2  output  4 each  current BCD count, registered.
REQ-008 running  output  1  high while state = RUN.
REQ-009 alarm  output  1  high while state = DONE.
REQ-010 expire  output  1  one-cycle pulse on entry to DONE.

Function
REQ-011 Block SHALL implement a 4-state FSM: IDLE, RUN, PAUSE, DONE.
REQ-012 load=1 in any state SHALL, at the next edge, copy set digits to d2..d0, clear the prescaler, and enter IDLE; load has priority over go.
REQ-013 Any set digit greater than 9 SHALL be loaded as 9.
REQ-014 IDLE with go=1 and count not 000 SHALL enter RUN; IDLE with go=1 and count 000 SHALL stay in IDLE and assert neither alarm nor expire.
REQ-015 In RUN, the prescaler SHALL increment by 1 each cycle; when it equals TICK_MAX-1 it SHALL wrap to 0 and the count SHALL decrement by 1 at that same edge.
REQ-016 Decrement SHALL be BCD with borrow: d0=0 becomes 9 and borrows from d1; d1=0 becomes 9 and borrows from d2; the count never wraps below 000.
REQ-017 The edge that makes the count 000 SHALL enter DONE and set expire for exactly that one following cycle.
REQ-018 RUN with go=0 SHALL enter PAUSE; PAUSE with go=1 SHALL return to RUN; the prescaler and the count SHALL hold in PAUSE.
REQ-019 DONE SHALL hold the count at 000 and alarm=1 until load or reset; go SHALL be ignored in DONE.
REQ-020 The first step after entering RUN from IDLE SHALL occur exactly TICK_MAX cycles later; after a pause, the step SHALL occur after the remaining prescaler cycles only.
REQ-021 All outputs SHALL be driven directly from registers, with no combinational path from any input.

Reset
REQ-022 clr=0 SHALL immediately, without waiting for a clock edge, force: state IDLE, prescaler 0, d0=d1=d2=0, running=0, alarm=0, expire=0.
REQ-023 Reset during RUN or DONE SHALL discard the current count; after release the block SHALL wait for load.
REQ-024 Operation SHALL resume at the first rising edge after clr returns to 1.

Structure
REQ-025 Package countdown_pkg SHALL hold: the state encoding typedef, the BCD_MAX=9 constant, and the default TICK_MAX.
REQ-026 The prescaler SHALL be one sub-module, countdown_tick_gen, with inputs clk, clr, en, sync_clear and output tick (a one-cycle strobe).
REQ-027 BCD borrow logic SHALL remain inside countdown_timer.

Verification (TICK_MAX=2 unless stated)
REQ-028 Assert clr=0 with arbitrary inputs -> all outputs 0 before the next clk edge; after release with go=1 and no load, the state stays IDLE.
REQ-029 Load 1,0,0 then go=1 -> count reads 099 two cycles after entering RUN, then 098 two cycles later.
REQ-030 Load 0,0,2 then go=1 -> 001, then 000 with expire high for one cycle and alarm held high; go toggling in DONE changes nothing.
REQ-031 Drop go for 10 cycles mid-count -> digits and prescaler frozen and running=0; re-raise go -> the step completes after the remaining 1 cycle.
REQ-032 Load F,A,3 -> count reads 993; load 0,0,5 during RUN -> count 005, state IDLE, running=0 the next cycle.
REQ-033 With TICK_MAX=3, pulse clr low between edges during RUN -> outputs clear asynchronously; a count of 000 at that moment produces no expire pulse.
